// File: rtl/imem_loader.sv
//============================================================================
// Module : imem_loader
// Boot-time byte-stream writer for instruction memory; holds the core in
// reset until the image is loaded. Option macro: LOADER_CHECKSUM_EN.
// Rev    : 1.0
//============================================================================
`default_nettype none

module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  input  logic              i_load_req,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_proc_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [15:0] c_DEPTH = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t            r_state;
  logic [15:0]       r_count;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_in_ready;
  logic              r_proc_reset;
  logic              r_done;
  logic              r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_count;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_count  = {r_count[15:8], i_in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_HDR_HI;
      r_count      <= 16'd0;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_addr       <= '0;
      r_waddr      <= '0;
      r_wdata      <= 32'd0;
      r_we         <= 1'b0;
      r_in_ready   <= 1'b1;
      r_proc_reset <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR_HI: begin
          if (w_accept) begin
            r_count[15:8] <= i_in_data;
            r_state       <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_accept) begin
            r_count <= w_count;
            if (w_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state    <= S_CHK;
`else
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
`endif
            end else if (w_count > c_DEPTH) begin
              r_state    <= S_ERROR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ i_in_data;
`endif
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {r_asm, i_in_data};
              r_waddr <= r_addr;
              r_addr  <= r_addr + 1'b1;
              r_count <= r_count - 16'd1;
              // r_count holds words still to come, so 1 means this is the last
              if (r_count == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
`endif
              end
            end else begin
              r_asm <= {r_asm[15:0], i_in_data};
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (i_in_data == r_csum) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERROR: begin
          if (i_load_req) begin
            r_state      <= S_HDR_HI;
            r_in_ready   <= 1'b1;
            r_proc_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_addr       <= '0;
            r_byte_cnt   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
          end else if (r_state == S_DONE) begin
            // Release lands one edge after the final write pulse began
            r_done       <= 1'b1;
            r_proc_reset <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_HDR_HI;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_waddr;
  assign o_imem_wdata = r_wdata;
  assign o_proc_reset = r_proc_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//============================================================================
// Module : tb_imem_loader
// Self-checking bench for imem_loader: random images against a word-list model.
// Rev    : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              load_req = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              proc_reset;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .i_load_req   (load_req),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_proc_reset (proc_reset),
    .o_done       (done),
    .o_error      (error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Image model: word i of the image must land at address i, once, in order
  logic [31:0]       img [0:DEPTH-1];
  logic [ADDR_W-1:0] wq_a [$];
  logic [31:0]       wq_d [$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_a.push_back(imem_addr);
      wq_d.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_image(input int n, input int gmin, input int gmax, input int lr_idx);
    logic [15:0] nn;
    logic [7:0]  cs;
    logic [7:0]  b;
    int          k;
    nn = 16'(n);
    cs = 8'd0;
    k  = 0;
    send_byte(nn[15:8], 0);
    send_byte(nn[7:0], 0);
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b  = img[i][8*j +: 8];
        cs = cs ^ b;
        if (k == lr_idx) load_req = 1'b1;
        send_byte(b, int'($urandom_range(gmax, gmin)));
        load_req = 1'b0;
        k++;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`endif
  endtask

  task automatic end_stream();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wq_a.delete();
    wq_d.delete();
  endtask

  task automatic wait_end(output int st);
    int t;
    t  = 0;
    st = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (done === 1'b1) st = 1;
    else if (error === 1'b1) st = 2;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, proc_reset, done, error} !==
        {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wdata=%h prst=%b done=%b err=%b, required 1 0 00 00000000 1 0 0",
               in_ready, imem_we, imem_addr, imem_wdata, proc_reset, done, error);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, imem_we, proc_reset, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy=%b we=%b prst=%b done=%b, required 1 0 1 0",
               in_ready, imem_we, proc_reset, done);
    end
  endtask

  task automatic test_basic();
    int st;
    wq_a.delete();
    wq_d.delete();
    img[0] = 32'h2008_0005;
    img[1] = 32'h2009_0007;
    send_image(2, 0, 0, -1);
    end_stream();
`ifndef LOADER_CHECKSUM_EN
    n_checks++;
    if ({imem_we, imem_addr, imem_wdata, done, proc_reset} !== {1'b1, 8'd1, 32'h2009_0007, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_last_pulse: we=%b addr=%h wdata=%h done=%b prst=%b, required 1 01 20090007 0 1",
               imem_we, imem_addr, imem_wdata, done, proc_reset);
    end
    @(negedge clk);
    n_checks++;
    if ({imem_we, done, proc_reset, in_ready} !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_release: we=%b done=%b prst=%b rdy=%b, required 0 1 0 0",
               imem_we, done, proc_reset, in_ready);
    end
`endif
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 2) begin
      n_fail++;
      $display("FAIL basic_status: status=%0d writes=%0d, required 1 and 2", st, wq_a.size());
    end
    for (int i = 0; i < 2 && i < wq_a.size(); i++) begin
      n_checks++;
      if (wq_a[i] !== ADDR_W'(i) || wq_d[i] !== img[i]) begin
        n_fail++;
        $display("FAIL basic_write[%0d]: addr=%h data=%h, required %h %h", i, wq_a[i], wq_d[i], ADDR_W'(i), img[i]);
      end
    end
  endtask

  task automatic test_reload();
    int st;
    restart();
    n_checks++;
    if ({in_ready, proc_reset, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL reload_enter: rdy=%b prst=%b done=%b, required 1 1 0", in_ready, proc_reset, done);
    end
    img[0] = 32'hAABB_CCDD;
    send_image(1, 0, 0, -1);
    n_checks++;
    if (proc_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_hold: prst=%b, required 1", proc_reset);
    end
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 1) begin
      n_fail++;
      $display("FAIL reload_status: status=%0d writes=%0d, required 1 and 1", st, wq_a.size());
    end else if (wq_a[0] !== 8'd0 || wq_d[0] !== 32'hAABB_CCDD) begin
      n_checks++;
      n_fail++;
      $display("FAIL reload_write: addr=%h data=%h, required 00 aabbccdd", wq_a[0], wq_d[0]);
    end
  endtask

  task automatic test_oversize();
    int st;
    restart();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    n_checks++;
    if ({error, in_ready, proc_reset, done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL oversize_error: err=%b rdy=%b prst=%b done=%b, required 1 0 1 0",
               error, in_ready, proc_reset, done);
    end
    in_data = 8'h5A;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (wq_a.size() !== 0 || in_ready !== 1'b0 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_idle: writes=%0d rdy=%b err=%b, required 0 0 1", wq_a.size(), in_ready, error);
    end
    restart();
    n_checks++;
    if ({error, in_ready, proc_reset} !== 3'b011) begin
      n_fail++;
      $display("FAIL oversize_restart: err=%b rdy=%b prst=%b, required 0 1 1", error, in_ready, proc_reset);
    end
    send_image(0, 0, 0, -1);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 0) begin
      n_fail++;
      $display("FAIL empty_image: status=%0d writes=%0d, required 1 and 0", st, wq_a.size());
    end
  endtask

  task automatic test_gapped();
    int st;
    restart();
    img[0] = 32'h2008_0005;
    img[1] = 32'h2009_0007;
    send_image(2, 1, 1, -1);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 2) begin
      n_fail++;
      $display("FAIL gapped_status: status=%0d writes=%0d, required 1 and 2", st, wq_a.size());
    end
    for (int i = 0; i < 2 && i < wq_a.size(); i++) begin
      n_checks++;
      if (wq_a[i] !== ADDR_W'(i) || wq_d[i] !== img[i]) begin
        n_fail++;
        $display("FAIL gapped_write[%0d]: addr=%h data=%h, required %h %h", i, wq_a[i], wq_d[i], ADDR_W'(i), img[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, proc_reset, done, error} !==
        {1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values: rdy=%b we=%b addr=%h wdata=%h prst=%b done=%b err=%b, required 1 0 00 00000000 1 0 0",
               in_ready, imem_we, imem_addr, imem_wdata, proc_reset, done, error);
    end
    @(negedge clk);
    reset = 1'b0;
    wq_a.delete();
    wq_d.delete();
    img[0] = 32'h1122_3344;
    send_image(1, 0, 0, -1);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 1) begin
      n_fail++;
      $display("FAIL midreset_status: status=%0d writes=%0d, required 1 and 1", st, wq_a.size());
    end else if (wq_a[0] !== 8'd0 || wq_d[0] !== 32'h1122_3344) begin
      n_checks++;
      n_fail++;
      $display("FAIL midreset_write: addr=%h data=%h, required 00 11223344", wq_a[0], wq_d[0]);
    end
  endtask

  task automatic test_random(input int n, input int gmax);
    int st;
    int lr;
    restart();
    for (int i = 0; i < n; i++) img[i] = $urandom;
    lr = (n > 1) ? int'($urandom_range(4 * n - 2, 0)) : -1;
    send_image(n, 0, gmax, lr);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== n) begin
      n_fail++;
      $display("FAIL random_status(n=%0d): status=%0d writes=%0d, required 1 and %0d", n, st, wq_a.size(), n);
    end
    for (int i = 0; i < n && i < wq_a.size(); i++) begin
      n_checks++;
      if (wq_a[i] !== ADDR_W'(i) || wq_d[i] !== img[i]) begin
        n_fail++;
        $display("FAIL random_write[%0d]: addr=%h data=%h, required %h %h", i, wq_a[i], wq_d[i], ADDR_W'(i), img[i]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int st;
    restart();
    img[0] = 32'h1234_5678;
    send_image(1, 0, 0, -1);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 1 || wq_a.size() !== 1) begin
      n_fail++;
      $display("FAIL csum_good: status=%0d writes=%0d, required 1 and 1", st, wq_a.size());
    end
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    send_byte(8'h09, 0);
    end_stream();
    wait_end(st);
    n_checks++;
    if (st !== 2 || proc_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_bad: status=%0d prst=%b rdy=%b done=%b, required 2 1 0 0", st, proc_reset, in_ready, done);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_oversize();
    test_gapped();
    test_reset_mid();
    for (int r = 0; r < 4; r++) test_random(int'($urandom_range(6, 1)), 2);
    test_random(DEPTH, 0);
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
